// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: accepts one control-transfer op, drives the comparison unit, registers redirect/flush/link outcome.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken/redirect counters.
module branch_resolve_unit #(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4,
  parameter int flushCycles = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   isBranch,
  input  logic                   isJal,
  input  logic                   isJalr,
  input  logic [2:0]             funct3,
  input  logic [dataWidth-1:0]   pcIn,
  input  logic [dataWidth-1:0]   immIn,
  input  logic [dataWidth-1:0]   rs1In,
  output logic [selectWidth-1:0] comparisonSelect,
  input  logic [dataWidth-1:0]   compareResult,
  output logic                   redirectValid,
  output logic [dataWidth-1:0]   redirectTarget,
  output logic                   flush,
  output logic                   linkValid,
  output logic [dataWidth-1:0]   linkData,
  output logic                   doneValid,
  output logic                   misaligned,
  output logic                   illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            statTaken,
  output logic [31:0]            statNotTaken,
  output logic [31:0]            statRedirect
`endif
);

  // state    | meaning
  // IDLE     | ready for a new op
  // RESOLVE  | captured op drives comparison unit, outcome computed
  // REDIRECT | first flush cycle after a taken redirect
  // FLUSH    | remaining flush cycles, counter running down
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(flushCycles - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic                   br_q, jal_q, jalr_q;
  logic [2:0]             f3_q;
  logic [dataWidth-1:0]   pc_q, imm_q, rs1_q;
  logic [selectWidth-1:0] sel_q;

  logic                   accept, resolve, type_ok, bad_f3, is_illegal, taken;
  logic                   legal, do_redirect, do_link, do_done, do_mis;
  logic [dataWidth-1:0]   jalr_sum, target, link_val;
  logic                   unused_cmp;

  function automatic logic [selectWidth-1:0] map_sel(input logic [2:0] f);
    case (f)
      3'b001:  map_sel = selectWidth'(1);
      3'b100:  map_sel = selectWidth'(2);
      3'b101:  map_sel = selectWidth'(8);
      3'b110:  map_sel = selectWidth'(3);
      3'b111:  map_sel = selectWidth'(9);
      default: map_sel = selectWidth'(0);
    endcase
  endfunction

  assign inReady          = (state_q == IDLE);
  assign flush            = (state_q == REDIRECT) || (state_q == FLUSH);
  assign comparisonSelect = sel_q;
  assign accept           = inValid && inReady;
  assign resolve          = (state_q == RESOLVE);
  assign unused_cmp       = ^compareResult[dataWidth-1:1];

  // funct3 only carries meaning for conditional branches
  assign type_ok    = (br_q && !jal_q && !jalr_q) || (!br_q && jal_q && !jalr_q) ||
                      (!br_q && !jal_q && jalr_q);
  assign bad_f3     = br_q && (f3_q == 3'b010 || f3_q == 3'b011);
  assign is_illegal = !type_ok || bad_f3;
  assign taken      = br_q ? compareResult[0] : 1'b1;
  assign jalr_sum   = rs1_q + imm_q;
  assign target     = jalr_q ? {jalr_sum[dataWidth-1:1], 1'b0} : (pc_q + imm_q);
  assign link_val   = pc_q + dataWidth'(4);

  assign legal       = resolve && !is_illegal;
  assign do_mis      = legal && taken && target[1];
  assign do_redirect = legal && taken && !target[1];
  assign do_link     = do_redirect && (jal_q || jalr_q);
  assign do_done     = legal && !do_mis;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (inValid) state_d = RESOLVE;
      RESOLVE:  state_d = do_redirect ? REDIRECT : IDLE;
      REDIRECT: state_d = (cnt_q == 4'd0) ? IDLE : FLUSH;
      FLUSH:    state_d = (cnt_q == 4'd0) ? IDLE : FLUSH;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      br_q           <= 1'b0;
      jal_q          <= 1'b0;
      jalr_q         <= 1'b0;
      f3_q           <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      sel_q          <= '0;
      redirectValid  <= 1'b0;
      redirectTarget <= '0;
      linkValid      <= 1'b0;
      linkData       <= '0;
      doneValid      <= 1'b0;
      misaligned     <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirectValid <= do_redirect;
      linkValid     <= do_link;
      doneValid     <= do_done;
      misaligned    <= do_mis;
      illegal       <= resolve && is_illegal;
      if (accept) begin
        br_q   <= isBranch;
        jal_q  <= isJal;
        jalr_q <= isJalr;
        f3_q   <= funct3;
        pc_q   <= pcIn;
        imm_q  <= immIn;
        rs1_q  <= rs1In;
        sel_q  <= map_sel(funct3);
      end
      if (do_redirect) begin
        redirectTarget <= target;
        cnt_q          <= FLUSH_LOAD;
      end else if (flush && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_link) linkData <= link_val;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      statTaken    <= '0;
      statNotTaken <= '0;
      statRedirect <= '0;
    end else begin
      if (legal && br_q && taken && statTaken != '1)     statTaken    <= statTaken + 32'd1;
      if (legal && br_q && !taken && statNotTaken != '1) statNotTaken <= statNotTaken + 32'd1;
      if (redirectValid && statRedirect != '1)           statRedirect <= statRedirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default build, flushCycles=2).
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        reset, inValid, inReady, isBranch, isJal, isJalr;
  logic [2:0]  funct3;
  logic [31:0] pcIn, immIn, rs1In, compareResult, redirectTarget, linkData;
  logic [3:0]  comparisonSelect;
  logic        redirectValid, flush, linkValid, doneValid, misaligned, illegal;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.dataWidth(32), .selectWidth(4), .flushCycles(2)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .isBranch(isBranch), .isJal(isJal), .isJalr(isJalr), .funct3(funct3),
    .pcIn(pcIn), .immIn(immIn), .rs1In(rs1In), .comparisonSelect(comparisonSelect),
    .compareResult(compareResult), .redirectValid(redirectValid),
    .redirectTarget(redirectTarget), .flush(flush), .linkValid(linkValid),
    .linkData(linkData), .doneValid(doneValid), .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulses(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, redirectValid, linkValid, doneValid, misaligned, illegal}, {27'd0, exp});
  endtask

  task automatic op(input logic b, input logic j, input logic jr, input logic [2:0] f,
                    input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                    input logic [31:0] cr);
    inValid = 1'b1; isBranch = b; isJal = j; isJalr = jr; funct3 = f;
    pcIn = pc; immIn = imm; rs1In = rs1; compareResult = cr;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; isBranch = 1'b0; isJal = 1'b0; isJalr = 1'b0;
    funct3 = '0; pcIn = '0; immIn = '0; rs1In = '0; compareResult = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_inready", {31'd0, inReady}, 32'd1);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_sel", {28'd0, comparisonSelect}, 32'd0);
    chk("rst_target", redirectTarget, 32'd0);
    chk("rst_link", linkData, 32'd0);
    pulses("rst_pulses", 5'b00000);

    // BEQ taken: target 0x120, flush high exactly 2 cycles
    op(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 32'h1);
    tick();
    inValid = 1'b0;
    chk("beq_resolve_ready", {31'd0, inReady}, 32'd0);
    chk("beq_sel", {28'd0, comparisonSelect}, 32'd0);
    pulses("beq_no_early_pulse", 5'b00000);
    tick();
    pulses("beq_pulses", 5'b10100);
    chk("beq_target", redirectTarget, 32'h120);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    tick();
    chk("beq_flush2", {31'd0, flush}, 32'd1);
    pulses("beq_pulses_off", 5'b00000);
    chk("beq_busy", {31'd0, inReady}, 32'd0);
    tick();
    chk("beq_flush_end", {31'd0, flush}, 32'd0);
    chk("beq_ready_end", {31'd0, inReady}, 32'd1);

    // reset held 3 cycles mid-FLUSH
    op(1, 0, 0, 3'b000, 32'h300, 32'h10, 32'h0, 32'h1);
    tick();
    inValid = 1'b0;
    tick();
    chk("rf_target", redirectTarget, 32'h310);
    tick();
    chk("rf_in_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rf_flush_drop", {31'd0, flush}, 32'd0);
    pulses("rf_pulses_rst", 5'b00000);
    tick(); tick();
    reset = 1'b0;
    chk("rf_ready", {31'd0, inReady}, 32'd1);
    chk("rf_target_clr", redirectTarget, 32'h0);
    tick();
    pulses("rf_pulses_after", 5'b00000);
    chk("rf_flush_after", {31'd0, flush}, 32'd0);

    // BLTU not taken, then BGE accepted 2 cycles later, inValid held through RESOLVE
    op(1, 0, 0, 3'b110, 32'h400, 32'h40, 32'h0, 32'h0);
    tick();
    inValid = 1'b0;
    chk("bltu_sel", {28'd0, comparisonSelect}, 32'd3);
    tick();
    pulses("bltu_pulses", 5'b00100);
    chk("bltu_flush", {31'd0, flush}, 32'd0);
    chk("bltu_ready", {31'd0, inReady}, 32'd1);
    op(1, 0, 0, 3'b101, 32'h500, 32'h40, 32'h0, 32'h0);
    tick();
    chk("bge_accepted", {31'd0, inReady}, 32'd0);
    chk("bge_sel", {28'd0, comparisonSelect}, 32'd8);
    tick();
    pulses("bge_pulses", 5'b00100);
    chk("bge_no_double_accept", {31'd0, inReady}, 32'd1);
    chk("bge_sel_hold", {28'd0, comparisonSelect}, 32'd8);
    inValid = 1'b0;
    tick();
    pulses("bge_pulses_off", 5'b00000);

    // JALR with wrapping link
    op(0, 0, 1, 3'b000, 32'hFFFF_FFFC, 32'h5, 32'h1003, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
    pulses("jalr_pulses", 5'b11100);
    chk("jalr_target", redirectTarget, 32'h1008);
    chk("jalr_link", linkData, 32'h0);
    chk("jalr_flush", {31'd0, flush}, 32'd1);
    tick(); tick();
    chk("jalr_flush_end", {31'd0, flush}, 32'd0);

    // JAL to misaligned target: link/target registers keep previous values
    op(0, 1, 0, 3'b000, 32'h200, 32'h6, 32'h0, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
    pulses("jal_mis_pulses", 5'b00010);
    chk("jal_mis_flush", {31'd0, flush}, 32'd0);
    chk("jal_mis_target_hold", redirectTarget, 32'h1008);
    chk("jal_mis_link_hold", linkData, 32'h0);
    chk("jal_mis_ready", {31'd0, inReady}, 32'd1);

    // JAL aligned: link = pc+4
    op(0, 1, 0, 3'b000, 32'h800, 32'h100, 32'h0, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
    pulses("jal_pulses", 5'b11100);
    chk("jal_target", redirectTarget, 32'h900);
    chk("jal_link", linkData, 32'h804);
    tick(); tick();

    // illegal: funct3=011 branch, then two type bits set
    op(1, 0, 0, 3'b011, 32'h600, 32'h8, 32'h0, 32'h1);
    tick();
    inValid = 1'b0;
    tick();
    pulses("ill_f3_pulses", 5'b00001);
    chk("ill_f3_flush", {31'd0, flush}, 32'd0);
    op(1, 1, 0, 3'b000, 32'h600, 32'h8, 32'h0, 32'h1);
    tick();
    inValid = 1'b0;
    tick();
    pulses("ill_type_pulses", 5'b00001);
    chk("ill_type_target_hold", redirectTarget, 32'h900);
    tick();
    pulses("ill_pulses_off", 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
